// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake and a two-entry (main + skid) buffer.
// in_ready is registered so there is no combinational out_ready -> in_ready path.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;

  logic accept;
  logic emit;

  assign accept = in_valid_i & in_ready_q;
  assign emit   = m_valid_q & out_ready_i;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;

    if (flush_i) begin
      m_valid_d = 1'b0;
      m_data_d  = NOP_VAL;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || emit) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data_i;
      end else begin
        // Bubble: main always shows the NOP payload when empty.
        m_valid_d = 1'b0;
        m_data_d  = NOP_VAL;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data_i;
    end

    // Mirrors !skid.valid but from its own flop so in_ready is a direct register output.
    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= NOP_VAL;
      s_valid_q  <= 1'b0;
      s_data_q   <= NOP_VAL;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      s_valid_q  <= s_valid_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = m_valid_q;
  assign out_data_o  = m_data_q;
  assign occupancy_o = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: reset, single beat, back-pressure,
// flush, full-rate stream with two stall cycles, and reset mid-operation.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W (32),
    .NOP_VAL(32'h0)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .occupancy_o(occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_data"}, out_data, 32'h0);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_occupancy"}, {30'b0, occupancy}, 32'd0);
  endtask

  logic [31:0] beats[100];

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b1;

    // Reset held two cycles with a beat offered.
    step();
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_idle("reset");
    step();
    check_idle("reset_after");

    // Single beat.
    in_valid = 1'b1;
    in_data  = 32'h13;
    step();
    in_valid = 1'b0;
    check("single_valid", {31'b0, out_valid}, 32'd1);
    check("single_data", out_data, 32'h13);
    step();
    check("single_bubble_valid", {31'b0, out_valid}, 32'd0);
    check("single_bubble_data", out_data, 32'h0);

    // Back-pressure fill and drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd1;
    step();
    check("bp_a_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_a_occ", {30'b0, occupancy}, 32'd1);
    in_data = 32'd2;
    step();
    check("bp_b_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_b_occ", {30'b0, occupancy}, 32'd2);
    check("bp_b_head", out_data, 32'd1);
    in_data = 32'd3;
    step();
    check("bp_c_held_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_c_held_occ", {30'b0, occupancy}, 32'd2);
    check("bp_c_held_head", out_data, 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_drain_2", out_data, 32'd2);
    check("bp_drain_2_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_drain_2_occ", {30'b0, occupancy}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_drain_3", out_data, 32'd3);
    check("bp_drain_3_valid", {31'b0, out_valid}, 32'd1);
    step();
    check_idle("bp_empty");

    // Flush with the stage full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd5;
    step();
    in_data = 32'd6;
    step();
    check("flush_full_occ", {30'b0, occupancy}, 32'd2);
    flush   = 1'b1;
    in_data = 32'd9;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_idle("flush_full");
    step();
    check("flush_full_no9", out_data, 32'h0);

    // Flush while a beat is accepted into a partly full stage: the beat is dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd7;
    step();
    flush   = 1'b1;
    in_data = 32'd9;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_idle("flush_accept");
    step();
    check_idle("flush_accept_after");

    // Full-rate stream, out_ready low in cycles 10 and 50.
    begin
      int sent = 0;
      int recv = 0;
      int cyc = 0;
      int first_emit = -1;
      int last_emit = -1;
      logic acc;
      logic emi;
      logic [31:0] emitted;
      for (int i = 0; i < 100; i++) beats[i] = $urandom;
      in_valid  = 1'b1;
      in_data   = beats[0];
      out_ready = 1'b1;
      while (recv < 100 && cyc < 400) begin
        acc     = in_valid & in_ready;
        emi     = out_valid & out_ready;
        emitted = out_data;
        step();
        if (emi) begin
          check("stream_data", emitted, beats[recv]);
          if (first_emit < 0) first_emit = cyc;
          last_emit = cyc;
          recv++;
        end
        if (acc) sent++;
        cyc++;
        in_valid  = (sent < 100);
        in_data   = (sent < 100) ? beats[sent] : 32'h0;
        out_ready = !(cyc == 10 || cyc == 50);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_count", recv, 32'd100);
      check("stream_span", last_emit - first_emit + 1, 32'd102);
      check_idle("stream_end");
    end

    // Reset mid-operation, coincident with an emit and an accept.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    step();
    check("rstmid_occ", {30'b0, occupancy}, 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h66;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_idle("rstmid");
    step();
    check_idle("rstmid_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
